alu_op_sequencer: RTL

Initiator-side driver for the team's 2-bit-opcode combinational ALU (AND/ADD/SUB a-b/RSUB b-a; zero, negative, overflow flags).
- Accepts commands over a valid/ready request channel and runs one or two ALU passes per command.
- Corrects flags the ALU does not produce; returns result and flags over a valid/ready response channel.
- Sits between the multicycle control unit and the ALU.

---
 rtl/alu_seq_pkg.sv | 45 ++++
 rtl/alu_flag_eval.sv | 72 +++++++
 rtl/alu_op_sequencer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the ALU operation sequencer.
//   - ALUOP_* : 2-bit opcodes understood by the combinational ALU
//   - CMD_*   : 3-bit command codes accepted on the request channel
//   - state_e : sequencer FSM states
//   - cmd_to_aluop() : opcode used for the first ALU pass of a command
package alu_seq_pkg;

  localparam logic [1:0] ALUOP_AND  = 2'b00;
  localparam logic [1:0] ALUOP_ADD  = 2'b01;
  localparam logic [1:0] ALUOP_SUB  = 2'b10;  // a - b
  localparam logic [1:0] ALUOP_RSUB = 2'b11;  // b - a

  localparam logic [2:0] CMD_AND  = 3'd0;
  localparam logic [2:0] CMD_ADD  = 3'd1;
  localparam logic [2:0] CMD_SUB  = 3'd2;
  localparam logic [2:0] CMD_RSUB = 3'd3;
  localparam logic [2:0] CMD_SLT  = 3'd4;
  localparam logic [2:0] CMD_EQ   = 3'd5;
  localparam logic [2:0] CMD_ABS  = 3'd6;
  localparam logic [2:0] CMD_ILL  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC1 = 2'd1,
    ST_EXEC2 = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // SLT, EQ and ABS are all built on a subtraction in the first pass.
  function automatic logic [1:0] cmd_to_aluop(input logic [2:0] cmd);
    logic [1:0] op;
    case (cmd)
      CMD_AND:  op = ALUOP_AND;
      CMD_ADD:  op = ALUOP_ADD;
      CMD_SUB:  op = ALUOP_SUB;
      CMD_RSUB: op = ALUOP_RSUB;
      CMD_SLT:  op = ALUOP_SUB;
      CMD_EQ:   op = ALUOP_SUB;
      CMD_ABS:  op = ALUOP_SUB;
      default:  op = ALUOP_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_flag_eval.sv
// alu_flag_eval: combinational post-processing of one ALU pass.
// Turns raw ALU outputs into the final command result and flags.
// Ports:
//   cmd_i          command being executed
//   pass2_i        1 while the second ABS pass (0 - a) is on the ALU
//   a_i, b_i       latched command operands
//   alu_*_i        raw ALU result and flags
//   result_o       final result
//   zero_o         result_o == 0
//   negative_o     result_o MSB
//   overflow_o     signed overflow of the command
//   need_pass2_o   first ABS pass saw a negative operand; negate it next
module alu_flag_eval
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        cmd_i,
  input  logic              pass2_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic              alu_zero_i,
  input  logic              alu_negative_i,
  input  logic              alu_overflow_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic              negative_o,
  output logic              overflow_o,
  output logic              need_pass2_o
);

  localparam int MSB = DATA_W - 1;

  logic sub_ovf;
  logic rsub_ovf;

  always_comb begin
    // The ALU only reports overflow for ADD, so subtraction overflow is
    // rebuilt here from the operand and result signs.
    sub_ovf  = (a_i[MSB] != b_i[MSB]) & (alu_result_i[MSB] != a_i[MSB]);
    rsub_ovf = (a_i[MSB] != b_i[MSB]) & (alu_result_i[MSB] != b_i[MSB]);

    result_o     = alu_result_i;
    overflow_o   = 1'b0;
    need_pass2_o = 1'b0;

    case (cmd_i)
      CMD_AND:  overflow_o = 1'b0;
      CMD_ADD:  overflow_o = alu_overflow_i;
      CMD_SUB:  overflow_o = sub_ovf;
      CMD_RSUB: overflow_o = rsub_ovf;
      // Signed less-than: the sign of a-b is wrong exactly when a-b overflowed.
      CMD_SLT:  result_o = {{(DATA_W-1){1'b0}}, alu_result_i[MSB] ^ sub_ovf};
      CMD_EQ:   result_o = {{(DATA_W-1){1'b0}}, alu_zero_i};
      CMD_ABS: begin
        if (pass2_i) begin
          // 0 - a overflows only for the most negative value, whose
          // negation stays negative.
          overflow_o = a_i[MSB] & alu_result_i[MSB];
        end else begin
          need_pass2_o = alu_negative_i;
        end
      end
      default:  result_o = '0;
    endcase

    zero_o     = (result_o == '0);
    negative_o = result_o[MSB];
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: drives the 2-bit-opcode combinational ALU on behalf of
// the multicycle control unit. One command in flight at a time; each takes
// one ALU pass, or two for ABS of a negative operand.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1. req_ready is 1 only in IDLE; rsp_valid is 1 only in RESP and
// rsp_* are held stable until the edge where rsp_ready is seen.
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   req_valid/ready/cmd/a/b  command channel
//   alu_op/a/b               drive to the ALU (00/0/0 when idle)
//   alu_result/zero/negative/overflow  from the ALU
//   rsp_valid/ready/result/zero/negative/overflow/err  response channel
//   ovf_sticky, ovf_clr      accumulated overflow flag and its clear
//   state_dbg                current FSM state (alu_seq_pkg::state_e)
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter bit ABS_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_cmd,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic [1:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_negative,
  input  logic              alu_overflow,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_negative,
  output logic              rsp_overflow,
  output logic              rsp_err,
  output logic              ovf_sticky,
  input  logic              ovf_clr,
  output logic [1:0]        state_dbg
);

  state_e              state_q, state_d;
  logic [2:0]          cmd_q, cmd_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic                zero_q, zero_d;
  logic                neg_q, neg_d;
  logic                ovf_q, ovf_d;
  logic                err_q, err_d;
  logic                sticky_q, sticky_d;

  logic                pass2;
  logic                capture;
  logic                req_illegal;
  logic [DATA_W-1:0]   ev_result;
  logic                ev_zero;
  logic                ev_negative;
  logic                ev_overflow;
  logic                ev_need_pass2;

  alu_flag_eval #(.DATA_W(DATA_W)) u_flag_eval (
    .cmd_i          (cmd_q),
    .pass2_i        (pass2),
    .a_i            (a_q),
    .b_i            (b_q),
    .alu_result_i   (alu_result),
    .alu_zero_i     (alu_zero),
    .alu_negative_i (alu_negative),
    .alu_overflow_i (alu_overflow),
    .result_o       (ev_result),
    .zero_o         (ev_zero),
    .negative_o     (ev_negative),
    .overflow_o     (ev_overflow),
    .need_pass2_o   (ev_need_pass2)
  );

  // ABS is rejected like cmd 7 when the feature is compiled out.
  assign req_illegal = (req_cmd == CMD_ILL) || ((req_cmd == CMD_ABS) && !ABS_EN);

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    zero_d    = zero_q;
    neg_d     = neg_q;
    ovf_d     = ovf_q;
    err_d     = err_q;
    pass2     = 1'b0;
    capture   = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    alu_op    = ALUOP_AND;
    alu_a     = '0;
    alu_b     = '0;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          cmd_d = req_cmd;
          a_d   = req_a;
          b_d   = req_b;
          if (req_illegal) begin
            // Rejected without touching the ALU.
            res_d   = '0;
            zero_d  = 1'b1;
            neg_d   = 1'b0;
            ovf_d   = 1'b0;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            state_d = ST_EXEC1;
          end
        end
      end
      ST_EXEC1: begin
        alu_op = cmd_to_aluop(cmd_q);
        alu_a  = a_q;
        alu_b  = (cmd_q == CMD_ABS) ? '0 : b_q;
        if (ev_need_pass2) begin
          state_d = ST_EXEC2;
        end else begin
          capture = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_EXEC2: begin
        // RSUB with b = 0 gives 0 - a.
        alu_op  = ALUOP_RSUB;
        alu_a   = a_q;
        alu_b   = '0;
        pass2   = 1'b1;
        capture = 1'b1;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (capture) begin
      res_d  = ev_result;
      zero_d = ev_zero;
      neg_d  = ev_negative;
      ovf_d  = ev_overflow;
      err_d  = 1'b0;
    end

    // A new overflow wins over a clear arriving on the same edge.
    sticky_d = (sticky_q & ~ovf_clr) | (capture & ev_overflow);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cmd_q    <= CMD_AND;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
    end
  end

  assign rsp_result   = res_q;
  assign rsp_zero     = zero_q;
  assign rsp_negative = neg_q;
  assign rsp_overflow = ovf_q;
  assign rsp_err      = err_q;
  assign ovf_sticky   = sticky_q;
  assign state_dbg    = state_q;

endmodule
